pic_usart: RTL and testbench
============================

Name: pic_usart

Overview:
- Asynchronous USART peripheral that sits directly downstream of the midrange core on its external peripheral bus.
- Decodes the core's 9-bit register-file address and consumes its write strobe and write data; returns read data to the core.
- Drives PIR1 interrupt strobes: RCIF on bit 5, TXIF on bit 4.
- Full-duplex 8N1 serial, 16x oversampled baud generator, double-buffered transmitter, receive FIFO.

Parameters:
- TXSTA_ADDR, 9'h098, TXSTA register address
- RCSTA_ADDR, 9'h018, RCSTA register address
- TXREG_ADDR, 9'h019, transmit buffer address
- RCREG_ADDR, 9'h01A, receive FIFO head address
- SPBRG_ADDR, 9'h099, baud divisor address
- RX_FIFO_DEPTH, 2, receive FIFO entries (>=1)

Ports:
- clk  in  1  core clock (Fosc)
- rst  in  1  synchronous active-high reset, from core rst_peripherals
- addr  in  9  core extern_peripherals_addr
- wr_en  in  1  core extern_peripherals_wr_en
- data_in  in  8  core extern_peripherals_data_in
- data_out  out  8  read data; 8'h00 when addr matches no USART register (OR-able)
- interrupt_strobes  out  8  one-cycle pulses; [5]=RCIF, [4]=TXIF, all other bits 0
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, idle high

Behaviour:
- Reset: tx=1, interrupt_strobes=0, SPBRG=0, TXSTA reads 8'h02, RCSTA=0, FIFO empty, TX buffer empty, all FSMs idle.
- Reads are combinational on addr and have no side effects.
- TXSTA bits: [5] TXEN (R/W), [1] TRMT (RO, 1 = shifter idle). All other bits read 0.
- RCSTA bits: [7] SPEN (R/W), [4] CREN (R/W), [2] FERR (RO, stop-bit error of the FIFO head), [1] OERR (RO, sticky). Other bits read 0.
- RCREG reads the FIFO head; reads 0 when empty.
- Writing RCREG (any data) pops the FIFO; popping when empty is ignored.
- Baud: counter reloads with SPBRG and emits tick16 every SPBRG+1 clks. One bit = 16 tick16 periods. Any SPBRG write restarts the counter.
- TX:
  - A TXREG write with SPEN&TXEN and buffer empty loads the buffer. A write while the buffer is full is dropped.
  - When the buffer is full and the shifter idle, the byte moves to the shifter in the next cycle; a TXIF strobe fires in that same cycle.
  - Frame: start 0, d0..d7 LSB first, stop 1, each 16 ticks.
  - TRMT=0 from the load cycle until the stop bit completes.
  - Back-to-back: a buffered byte loads on the cycle after the stop bit ends.
- RX:
  - rx passes through a 2-flop synchroniser.
  - FSM: IDLE -> START on a falling edge while SPEN&CREN.
  - START waits 8 ticks, then samples: 1 -> IDLE (false start), 0 -> DATA.
  - DATA samples every 16 ticks, 8 bits, LSB first -> STOP.
  - STOP samples after 16 ticks, pushes {ferr=~stop, byte}, then returns to IDLE.
  - The RCIF strobe fires in the push cycle.
  - If the FIFO is full at push: byte discarded, OERR=1, no RCIF.
  - While OERR=1, reception is blocked; the FSM stays in IDLE.
- CREN cleared: RX FSM to IDLE, OERR cleared, FIFO contents retained.
- TXEN cleared: shifter aborts, tx=1, TX buffer cleared, TRMT=1.
- SPEN cleared: both FSMs idle, FIFO flushed, TX buffer cleared, tx=1.
- Simultaneous push and pop on a full FIFO: pop first, push succeeds, no OERR.
- Reset asserted mid-frame: all state returns to reset values on the next edge; tx=1 immediately after.

Optional Feature:
- Macro: PIC_USART_LOOPBACK_EN.
- Defined: TXSTA[3] LPBK is R/W, reset 0. When 1, the receiver input is the internal tx signal (before the pin), and the tx pin is held 1.
- Undefined: TXSTA[3] reads 0, writes are ignored, and the receiver always uses the synchronised rx.

Test Plan:
- SPBRG=0, SPEN=1, TXEN=1, write TXREG=0xA5:
  - TXIF pulses 1 cycle later.
  - tx low 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then high.
  - TRMT=0 throughout, 1 after the stop bit.
- SPBRG=3, CREN=1, drive an rx frame 0x3C at 64 clks/bit:
  - RCIF pulses once.
  - RCREG reads 0x3C, FERR=0.
  - After an RCREG write, RCREG reads 0.
- Depth 2, receive 0x11, 0x22, 0x33 without popping:
  - OERR=1, only two RCIF pulses.
  - Clear CREN -> OERR=0, RCREG=0x11; pop -> 0x22.
- Frame 0x55 with stop=0, then 0x66 with a good stop:
  - FERR=1 with head 0x55.
  - After a pop, head 0x66 and FERR=0.
- rx low glitch of 4 clks at SPBRG=0 -> no RCIF, FSM back in IDLE, FIFO empty.
- Assert rst at mid-bit 3 of a TX frame -> tx=1 next cycle, TXSTA=0x02, SPBRG=0, no TXIF.

Source files
------------

// File: rtl/pic_usart.sv
// pic_usart: 8N1 USART on the midrange core peripheral bus (16x baud, buffered TX, RX FIFO).
// Define PIC_USART_LOOPBACK_EN to enable TXSTA[3] LPBK (receiver fed from internal tx, pin held high).
module pic_usart #(
   parameter logic [8:0]  TXSTA_ADDR    = 9'h098,
   parameter logic [8:0]  RCSTA_ADDR    = 9'h018,
   parameter logic [8:0]  TXREG_ADDR    = 9'h019,
   parameter logic [8:0]  RCREG_ADDR    = 9'h01A,
   parameter logic [8:0]  SPBRG_ADDR    = 9'h099,
   parameter int unsigned RX_FIFO_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] addr,
   input  logic       wr_en,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [7:0] interrupt_strobes,
   input  logic       rx,
   output logic       tx
);
   localparam int unsigned CW = $clog2(RX_FIFO_DEPTH + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   logic       wr_txsta, wr_rcsta, wr_txreg, wr_rcreg, wr_spbrg;
   logic [7:0] spbrg_q, baud_cnt_q;
   logic       txen_q, spen_q, cren_q;
   logic       tick, tx_en, rx_en, lpbk, trmt;

   tx_state_e  tx_state_q;
   logic [3:0] tcnt_q;
   logic [2:0] tbit_q;
   logic [7:0] tsr_q, txbuf_q;
   logic       txbuf_full_q, tx_q, txif_q;

   rx_state_e  rx_state_q;
   logic [3:0] rcnt_q;
   logic [2:0] rbit_q;
   logic [7:0] rsr_q;
   logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_in, rx_fall;

   logic [8:0]    fifo_q [RX_FIFO_DEPTH];
   logic [8:0]    fifo_d [RX_FIFO_DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic          oerr_q, oerr_d, rcif_q, rcif_d;
   logic          pop, push;
   logic [8:0]    head;

   assign wr_txsta = wr_en && (addr == TXSTA_ADDR);
   assign wr_rcsta = wr_en && (addr == RCSTA_ADDR);
   assign wr_txreg = wr_en && (addr == TXREG_ADDR);
   assign wr_rcreg = wr_en && (addr == RCREG_ADDR);
   assign wr_spbrg = wr_en && (addr == SPBRG_ADDR);

   assign tx_en = spen_q & txen_q;
   assign rx_en = spen_q & cren_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         spbrg_q <= '0;
         txen_q  <= 1'b0;
         spen_q  <= 1'b0;
         cren_q  <= 1'b0;
      end else begin
         if (wr_spbrg) spbrg_q <= data_in;
         if (wr_txsta) txen_q <= data_in[5];
         if (wr_rcsta) begin
            spen_q <= data_in[7];
            cren_q <= data_in[4];
         end
      end
   end

`ifdef PIC_USART_LOOPBACK_EN
   logic lpbk_q;
   always_ff @(posedge clk) begin
      if (rst)           lpbk_q <= 1'b0;
      else if (wr_txsta) lpbk_q <= data_in[3];
   end
   assign lpbk = lpbk_q;
`else
   assign lpbk = 1'b0;
`endif

   // Down-counter: tick16 on reaching zero, then reload; an SPBRG write restarts it.
   assign tick = (baud_cnt_q == '0);
   always_ff @(posedge clk) begin
      if (rst)           baud_cnt_q <= '0;
      else if (wr_spbrg) baud_cnt_q <= data_in;
      else if (tick)     baud_cnt_q <= spbrg_q;
      else               baud_cnt_q <= baud_cnt_q - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q   <= TX_IDLE;
         tcnt_q       <= '0;
         tbit_q       <= '0;
         tsr_q        <= '0;
         txbuf_q      <= '0;
         txbuf_full_q <= 1'b0;
         tx_q         <= 1'b1;
         txif_q       <= 1'b0;
      end else begin
         txif_q <= 1'b0;
         if (!tx_en) begin
            tx_state_q   <= TX_IDLE;
            txbuf_full_q <= 1'b0;
            tx_q         <= 1'b1;
         end else begin
            if (wr_txreg && !txbuf_full_q) begin
               txbuf_q      <= data_in;
               txbuf_full_q <= 1'b1;
            end
            case (tx_state_q)
               TX_IDLE: begin
                  if (txbuf_full_q) begin
                     tsr_q        <= txbuf_q;
                     txbuf_full_q <= 1'b0;
                     tcnt_q       <= '0;
                     tx_q         <= 1'b0;
                     txif_q       <= 1'b1;
                     tx_state_q   <= TX_START;
                  end
               end
               TX_START: begin
                  if (tick) begin
                     if (tcnt_q == 4'd15) begin
                        tcnt_q     <= '0;
                        tbit_q     <= '0;
                        tx_q       <= tsr_q[0];
                        tsr_q      <= {1'b0, tsr_q[7:1]};
                        tx_state_q <= TX_DATA;
                     end else begin
                        tcnt_q <= tcnt_q + 4'd1;
                     end
                  end
               end
               TX_DATA: begin
                  if (tick) begin
                     if (tcnt_q == 4'd15) begin
                        tcnt_q <= '0;
                        if (tbit_q == 3'd7) begin
                           tx_q       <= 1'b1;
                           tx_state_q <= TX_STOP;
                        end else begin
                           tbit_q <= tbit_q + 3'd1;
                           tx_q   <= tsr_q[0];
                           tsr_q  <= {1'b0, tsr_q[7:1]};
                        end
                     end else begin
                        tcnt_q <= tcnt_q + 4'd1;
                     end
                  end
               end
               TX_STOP: begin
                  if (tick) begin
                     if (tcnt_q == 4'd15) tx_state_q <= TX_IDLE;
                     else                 tcnt_q     <= tcnt_q + 4'd1;
                  end
               end
               default: tx_state_q <= TX_IDLE;
            endcase
         end
      end
   end

   assign trmt = (tx_state_q == TX_IDLE) && !txbuf_full_q;
   assign tx   = tx_q | lpbk;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_in;
      end
   end

   assign rx_in   = lpbk ? tx_q : rx_s2_q;
   assign rx_fall = rx_prev_q & ~rx_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rcnt_q     <= '0;
         rbit_q     <= '0;
         rsr_q      <= '0;
      end else if (!rx_en) begin
         rx_state_q <= RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall && !oerr_q) begin
                  rcnt_q     <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rcnt_q == 4'd7) begin
                     rcnt_q     <= '0;
                     rbit_q     <= '0;
                     rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
                  end else begin
                     rcnt_q <= rcnt_q + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rcnt_q == 4'd15) begin
                     rcnt_q <= '0;
                     rsr_q  <= {rx_in, rsr_q[7:1]};
                     rbit_q <= rbit_q + 3'd1;
                     if (rbit_q == 3'd7) rx_state_q <= RX_STOP;
                  end else begin
                     rcnt_q <= rcnt_q + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (rcnt_q == 4'd15) rx_state_q <= RX_IDLE;
                  else                 rcnt_q     <= rcnt_q + 4'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign pop  = wr_rcreg && (cnt_q != '0);
   assign push = rx_en && (rx_state_q == RX_STOP) && tick && (rcnt_q == 4'd15);

   // Pop is applied before push so a full FIFO popped in the push cycle accepts the byte.
   always_comb begin
      fifo_d = fifo_q;
      cnt_d  = cnt_q;
      oerr_d = oerr_q;
      rcif_d = 1'b0;
      if (pop) begin
         for (int unsigned i = 0; i + 1 < RX_FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i+1];
         cnt_d = cnt_q - CW'(1);
      end
      if (push) begin
         if (cnt_d < CW'(RX_FIFO_DEPTH)) begin
            for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) begin
               if (CW'(i) == cnt_d) fifo_d[i] = {~rx_in, rsr_q};
            end
            cnt_d  = cnt_d + CW'(1);
            rcif_d = 1'b1;
         end else begin
            oerr_d = 1'b1;
         end
      end
      if (!cren_q) oerr_d = 1'b0;
      if (!spen_q) cnt_d  = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
         cnt_q  <= '0;
         oerr_q <= 1'b0;
         rcif_q <= 1'b0;
      end else begin
         fifo_q <= fifo_d;
         cnt_q  <= cnt_d;
         oerr_q <= oerr_d;
         rcif_q <= rcif_d;
      end
   end

   assign head              = (cnt_q != '0) ? fifo_q[0] : '0;
   assign interrupt_strobes = {2'b00, rcif_q, txif_q, 4'b0000};

   always_comb begin
      data_out = '0;
      if (addr == TXSTA_ADDR)      data_out = {2'b00, txen_q, 1'b0, lpbk, 1'b0, trmt, 1'b0};
      else if (addr == RCSTA_ADDR) data_out = {spen_q, 2'b00, cren_q, 1'b0, head[8], oerr_q, 1'b0};
      else if (addr == RCREG_ADDR) data_out = head[7:0];
      else if (addr == SPBRG_ADDR) data_out = spbrg_q;
   end

endmodule

// File: tb/tb_pic_usart.sv
// Directed self-checking bench for pic_usart: TX framing, RX/FIFO, overrun, framing error, glitch, reset.
`timescale 1ns/1ps
module tb_pic_usart;
   localparam logic [8:0] A_TXSTA = 9'h098;
   localparam logic [8:0] A_RCSTA = 9'h018;
   localparam logic [8:0] A_TXREG = 9'h019;
   localparam logic [8:0] A_RCREG = 9'h01A;
   localparam logic [8:0] A_SPBRG = 9'h099;

   logic       clk, rst, wr_en, rx, tx;
   logic [8:0] addr;
   logic [7:0] data_in, data_out, interrupt_strobes;

   int vectors     = 0;
   int miscompares = 0;
   int rcif_cnt    = 0;
   int txif_cnt    = 0;
   int base;
   logic [9:0] frame;

   pic_usart #(
      .RX_FIFO_DEPTH(2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .addr             (addr),
      .wr_en            (wr_en),
      .data_in          (data_in),
      .data_out         (data_out),
      .interrupt_strobes(interrupt_strobes),
      .rx               (rx),
      .tx               (tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (interrupt_strobes[5] === 1'b1) rcif_cnt <= rcif_cnt + 1;
      if (interrupt_strobes[4] === 1'b1) txif_cnt <= txif_cnt + 1;
   end

   initial begin
      #900_000;
      $display("FAIL timeout: observed no completion, expected finish before 900us");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      addr    = a;
      data_in = d;
      wr_en   = 1'b1;
      tick_n(1);
      wr_en   = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [8:0] a, input logic [7:0] exp);
      addr = a;
      tick_n(1);
      check(tag, data_out, exp);
   endtask

   task automatic send(input logic [7:0] b, input logic stopb, input int cpb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         tick_n(cpb);
      end
      rx = 1'b1;
      tick_n(32);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; addr = '0; data_in = '0; rx = 1'b1;
      tick_n(3);
      check("rst_tx", {7'b0, tx}, 8'h01);
      check("rst_strobes", interrupt_strobes, 8'h00);
      rst = 1'b0;
      chk_reg("rst_txsta", A_TXSTA, 8'h02);
      chk_reg("rst_rcsta", A_RCSTA, 8'h00);
      chk_reg("rst_spbrg", A_SPBRG, 8'h00);
      chk_reg("rst_rcreg", A_RCREG, 8'h00);

      // TX 0xA5 at SPBRG=0: 16 clks per bit
      wr(A_RCSTA, 8'h80);
      wr(A_TXSTA, 8'h20);
      chk_reg("txen_txsta", A_TXSTA, 8'h22);
      wr(A_TXREG, 8'hA5);
      addr = A_TXSTA;
      check("txif_early", interrupt_strobes, 8'h00);
      tick_n(1);
      check("txif_pulse", interrupt_strobes, 8'h10);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 16; c++) begin
            check("tx_bit", {7'b0, tx}, {7'b0, frame[b]});
            check("tx_trmt", data_out, 8'h20);
            if (b != 0 || c != 0) check("tx_no_strobe", interrupt_strobes, 8'h00);
            tick_n(1);
         end
      end
      check("tx_idle", {7'b0, tx}, 8'h01);
      check("tx_trmt_done", data_out, 8'h22);

      // RX 0x3C at SPBRG=3: 64 clks per bit
      wr(A_SPBRG, 8'h03);
      wr(A_RCSTA, 8'h90);
      base = rcif_cnt;
      send(8'h3C, 1'b1, 64);
      check("rx_rcif_one", 8'(rcif_cnt - base), 8'd1);
      chk_reg("rx_rcreg", A_RCREG, 8'h3C);
      chk_reg("rx_rcsta", A_RCSTA, 8'h90);
      wr(A_RCREG, 8'h00);
      chk_reg("rx_popped", A_RCREG, 8'h00);

      // overrun: three frames into a two-entry FIFO
      base = rcif_cnt;
      send(8'h11, 1'b1, 64);
      send(8'h22, 1'b1, 64);
      send(8'h33, 1'b1, 64);
      check("ovr_rcif_two", 8'(rcif_cnt - base), 8'd2);
      chk_reg("ovr_oerr", A_RCSTA, 8'h92);
      chk_reg("ovr_head", A_RCREG, 8'h11);
      wr(A_RCSTA, 8'h80);
      chk_reg("ovr_cleared", A_RCSTA, 8'h80);
      chk_reg("ovr_kept", A_RCREG, 8'h11);
      wr(A_RCREG, 8'h00);
      chk_reg("ovr_second", A_RCREG, 8'h22);
      wr(A_RCREG, 8'h00);
      chk_reg("ovr_empty", A_RCREG, 8'h00);
      wr(A_RCSTA, 8'h90);

      // framing error on head, then good frame
      base = rcif_cnt;
      send(8'h55, 1'b0, 64);
      send(8'h66, 1'b1, 64);
      check("ferr_rcif_two", 8'(rcif_cnt - base), 8'd2);
      chk_reg("ferr_head", A_RCREG, 8'h55);
      chk_reg("ferr_set", A_RCSTA, 8'h94);
      wr(A_RCREG, 8'h00);
      chk_reg("ferr_next", A_RCREG, 8'h66);
      chk_reg("ferr_clear", A_RCSTA, 8'h90);
      wr(A_RCREG, 8'h00);

      // 4-clk glitch at SPBRG=0 must be rejected, then a real frame still received
      wr(A_SPBRG, 8'h00);
      base = rcif_cnt;
      rx = 1'b0;
      tick_n(4);
      rx = 1'b1;
      tick_n(40);
      check("glitch_no_rcif", 8'(rcif_cnt - base), 8'd0);
      chk_reg("glitch_empty", A_RCREG, 8'h00);
      chk_reg("glitch_rcsta", A_RCSTA, 8'h90);
      send(8'h81, 1'b1, 16);
      check("glitch_then_rcif", 8'(rcif_cnt - base), 8'd1);
      chk_reg("glitch_then_byte", A_RCREG, 8'h81);
      wr(A_RCREG, 8'h00);

      // reset in the middle of data bit 3 of 0x52 (bit3 = 0) at SPBRG=1
      wr(A_SPBRG, 8'h01);
      wr(A_TXREG, 8'h52);
      tick_n(1);
      check("rst_frame_txif", interrupt_strobes, 8'h10);
      tick_n(143);
      check("rst_frame_bit3", {7'b0, tx}, 8'h00);
      addr = A_TXSTA;
      base = txif_cnt;
      rst = 1'b1;
      tick_n(1);
      check("rst_mid_tx", {7'b0, tx}, 8'h01);
      check("rst_mid_txsta", data_out, 8'h02);
      check("rst_mid_strobes", interrupt_strobes, 8'h00);
      addr = A_SPBRG;
      tick_n(1);
      check("rst_mid_spbrg", data_out, 8'h00);
      rst = 1'b0;
      tick_n(200);
      check("rst_mid_no_txif", 8'(txif_cnt - base), 8'd0);
      check("rst_mid_tx_idle", {7'b0, tx}, 8'h01);
      chk_reg("rst_mid_rcsta", A_RCSTA, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
